// File: rtl/sdpram_fifo_ctrl_if.sv
// Stream handshake bundle for the SDP-RAM FIFO controller.
// The producer/consumer side uses master and the controller uses slave.
interface sdpram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// FIFO controller over a simple dual-port RAM: port-A writes for accepted beats,
// port-B reads that refill a small output buffer feeding the consumer.
module sdpram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int OBUF_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   sdpram_fifo_ctrl_if.slave     st,
   output logic [STRB_WIDTH-1:0] wena,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   output logic                  renb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   input  logic                  dvalb,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  err_unexp
);

   localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
   localparam int PTR_W     = ADDR_WIDTH + 1;
   localparam int OCC_W     = $clog2(OBUF_DEPTH + 1);
   localparam int IDX_W     = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int CNT_W     = OCC_W + 1;

   logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_cmt;
   logic [PTR_W-1:0]      wr_ptr_d, rd_ptr_d, wr_cmt_d;
   logic [PTR_W-1:0]      fill, level_d;
   logic [CNT_W-1:0]      inflight, discard, inflight_d, discard_d;
   logic [OCC_W-1:0]      occ, occ_d;
   logic [IDX_W-1:0]      head, tail;
   logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
   logic [CNT_W:0]        buf_claim;
   logic                  accept, issue, pop, push;
   logic                  ret_drop, ret_take, ret_err;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(OBUF_DEPTH - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   assign fill       = wr_ptr - rd_ptr;
   assign st.s_ready = ~rst & (fill != PTR_W'(MEM_DEPTH));
   assign st.m_valid = (occ != '0);
   assign st.m_data  = obuf[head];

   assign accept = st.s_valid & st.s_ready & ~flush;
   assign pop    = st.m_valid & st.m_ready & ~flush;

   // Returns from reads issued before a flush drain the discard count first,
   // since they arrive ahead of any read issued afterwards.
   assign ret_drop = dvalb & (discard != '0);
   assign ret_take = dvalb & (discard == '0) & (inflight != '0);
   assign ret_err  = dvalb & (discard == '0) & (inflight == '0);
   assign push     = ret_take & ~flush;

   // Buffer space is reserved at issue time so a return always has a slot.
   assign buf_claim = (CNT_W+1)'(occ) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
   assign issue     = (rd_ptr != wr_cmt) & (buf_claim < (CNT_W+1)'(OBUF_DEPTH)) & ~flush;

   always_comb begin
      wr_ptr_d   = wr_ptr + PTR_W'(accept);
      rd_ptr_d   = rd_ptr + PTR_W'(issue);
      wr_cmt_d   = wr_cmt + PTR_W'(wena != '0);
      inflight_d = inflight + CNT_W'(issue) - CNT_W'(ret_take);
      discard_d  = discard - CNT_W'(ret_drop);
      occ_d      = occ + OCC_W'(push) - OCC_W'(pop);
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         wr_cmt_d   = '0;
         inflight_d = '0;
         discard_d  = discard - CNT_W'(ret_drop) + inflight - CNT_W'(ret_take);
         occ_d      = '0;
      end
      level_d = (wr_ptr_d - rd_ptr_d) + PTR_W'(inflight_d) + PTR_W'(occ_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wr_cmt    <= '0;
         inflight  <= '0;
         discard   <= '0;
         occ       <= '0;
         head      <= '0;
         tail      <= '0;
         level     <= '0;
         err_unexp <= 1'b0;
         wena      <= '0;
         addra     <= '0;
         dina      <= '0;
         renb      <= 1'b0;
         addrb     <= '0;
         for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
      end else begin
         wr_ptr   <= wr_ptr_d;
         rd_ptr   <= rd_ptr_d;
         wr_cmt   <= wr_cmt_d;
         inflight <= inflight_d;
         discard  <= discard_d;
         occ      <= occ_d;
         level    <= level_d;
         if (ret_err) err_unexp <= 1'b1;

         // Write stage: one port-A pulse per accepted beat.
         wena <= {STRB_WIDTH{accept}};
         if (accept) begin
            addra <= wr_ptr[ADDR_WIDTH-1:0];
            dina  <= st.s_data;
         end

         // Read stage: port-B request for the next committed word.
         renb <= issue;
         if (issue) addrb <= rd_ptr[ADDR_WIDTH-1:0];

         // Return stage: read data lands at the buffer tail.
         if (push) begin
            obuf[tail] <= doutb;
            tail       <= idx_inc(tail);
         end
         if (pop) head <= idx_inc(head);
         if (flush) begin
            head <= '0;
            tail <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Bench for sdpram_fifo_ctrl: RAM model on the ports, queue-based reference
// for data order and occupancy, directed latency/flush cases plus random traffic.
module tb_sdpram_fifo_ctrl;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int OD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [SW-1:0] wena;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, doutb;
   logic          renb, dvalb;
   logic [AW:0]   level;
   logic          err_unexp;

   always #5 clk = ~clk;

   sdpram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   sdpram_fifo_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .OBUF_DEPTH(OD)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .st(bus),
      .wena(wena), .addra(addra), .dina(dina),
      .renb(renb), .addrb(addrb), .doutb(doutb), .dvalb(dvalb),
      .level(level), .err_unexp(err_unexp)
   );

   // RAM with one-cycle read latency; stray injects an unsolicited return.
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] ram_q;
   logic          ram_dval, stray;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_dval <= 1'b0;
         ram_q    <= '0;
      end else begin
         for (int j = 0; j < SW; j++)
            if (wena[j]) mem[addra][8*j +: 8] <= dina[8*j +: 8];
         ram_dval <= renb;
         if (renb) ram_q <= mem[addrb];
      end
   end

   assign doutb = ram_q;
   assign dvalb = ram_dval | stray;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] q [$];
   int            cyc = 0;
   int            n_pop = 0;
   int            n_push = 0;
   int            first_pop = -1;
   int            last_pop = -1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called at a falling edge: apply inputs, score the handshakes that the
   // next rising edge will perform, and return at the following falling edge.
   task automatic run_cycle(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
      bus.s_valid = sv;
      bus.s_data  = sd;
      bus.m_ready = mr;
      flush       = fl;
      check_val("level", 64'(level), 64'(q.size()));
      if (fl) begin
         q.delete();
      end else begin
         if (bus.m_valid && mr) begin
            check_val("pop_avail", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) check_val("m_data", 64'(bus.m_data), 64'(q.pop_front()));
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (sv && bus.s_ready) begin
            q.push_back(sd);
            n_push++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input string tag);
      int g = 0;
      while (q.size() > 0 && g < 3000) begin
         run_cycle(1'b0, '0, 1'b1, 1'b0);
         g++;
      end
      check_val(tag, 64'(q.size()), 64'd0);
      repeat (2) run_cycle(1'b0, '0, 1'b1, 1'b0);
      check_val({tag, "_mvalid"}, 64'(bus.m_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int p0;
      rst         = 1'b1;
      flush       = 1'b0;
      stray       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_s_ready", 64'(bus.s_ready), 64'd0);
      check_val("rst_wena", 64'(wena), 64'd0);
      check_val("rst_addra", 64'(addra), 64'd0);
      check_val("rst_dina", 64'(dina), 64'd0);
      check_val("rst_renb", 64'(renb), 64'd0);
      check_val("rst_addrb", 64'(addrb), 64'd0);
      check_val("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check_val("rst_m_data", 64'(bus.m_data), 64'd0);
      check_val("rst_level", 64'(level), 64'd0);
      check_val("rst_err", 64'(err_unexp), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("rel_s_ready", 64'(bus.s_ready), 64'd1);
      check_val("rel_level", 64'(level), 64'd0);

      // Single beat latency
      run_cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      check_val("sb_wena", 64'(wena), 64'hF);
      check_val("sb_addra", 64'(addra), 64'd0);
      check_val("sb_dina", 64'(dina), 64'hDEADBEEF);
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("sb_wena_off", 64'(wena), 64'd0);
      check_val("sb_renb_early", 64'(renb), 64'd0);
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("sb_renb", 64'(renb), 64'd1);
      check_val("sb_addrb", 64'(addrb), 64'd0);
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("sb_mvalid_early", 64'(bus.m_valid), 64'd0);
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("sb_mvalid", 64'(bus.m_valid), 64'd1);
      check_val("sb_mdata", 64'(bus.m_data), 64'hDEADBEEF);
      run_cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("sb_popped", 64'(bus.m_valid), 64'd0);

      // Fill to full with the consumer stalled, then drain in order
      acc = 0;
      while (bus.s_ready && acc < 1000) begin
         run_cycle(1'b1, DW'(acc), 1'b0, 1'b0);
         acc++;
      end
      check_val("fill_count", 64'(acc), 64'd260);
      repeat (3) run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("fill_level", 64'(level), 64'd260);
      check_val("fill_s_ready", 64'(bus.s_ready), 64'd0);
      p0 = n_pop;
      drain("fill_drain");
      check_val("fill_pops", 64'(n_pop - p0), 64'd260);

      // Streaming at full rate across several address wraps
      p0        = n_pop;
      acc       = n_push;
      first_pop = -1;
      for (int i = 0; i < 1000; i++) run_cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
      check_val("stream_push", 64'(n_push - acc), 64'd1000);
      drain("stream_drain");
      check_val("stream_pops", 64'(n_pop - p0), 64'd1000);
      check_val("stream_span", 64'(last_pop - first_pop), 64'd999);

      // Random producer and consumer backpressure
      for (int i = 0; i < 3000; i++)
         run_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      drain("bp_drain");
      check_val("err_clean", 64'(err_unexp), 64'd0);

      // Flush with reads outstanding
      run_cycle(1'b1, 32'hA0A0A0A0, 1'b0, 1'b0);
      run_cycle(1'b1, 32'hB1B1B1B1, 1'b0, 1'b0);
      run_cycle(1'b1, 32'hC2C2C2C2, 1'b0, 1'b0);
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("fl_renb", 64'(renb), 64'd1);
      check_val("fl_dvalb", 64'(dvalb), 64'd1);
      run_cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check_val("fl_mvalid", 64'(bus.m_valid), 64'd0);
         check_val("fl_err", 64'(err_unexp), 64'd0);
         run_cycle(1'b0, '0, 1'b1, 1'b0);
      end
      check_val("fl_level", 64'(level), 64'd0);
      stray = 1'b1;
      run_cycle(1'b0, '0, 1'b0, 1'b0);
      stray = 1'b0;
      check_val("stray_err", 64'(err_unexp), 64'd1);

      // FIFO remains usable after a flush
      for (int i = 0; i < 200; i++)
         run_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      drain("post_flush_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
